// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds the FSM state enum, funct3 encodings and default parameters.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int AW_DEFAULT      = 32;

  // Unsigned variants exist only for loads.
  function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = is_load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the access controller (master) and the memory (slave).
interface mem_access_ctrl_if
  import mem_access_ctrl_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) ();

  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_be;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_access_ctrl_lsu_align.sv
// Combinational load/store lane logic: legality and alignment check, store
// byte enables and replication, and load lane extraction with sign handling.
module lsu_align
  import mem_access_ctrl_pkg::*;
(
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic        op_ok,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  logic        aligned_s;
  logic [31:0] lane_s;

  // Legality: funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    aligned_s = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned_s = 1'b1;
      2'b01:   aligned_s = ~addr_lo[0];
      2'b10:   aligned_s = (addr_lo == 2'b00);
      default: aligned_s = 1'b0;
    endcase
    op_ok = f3_legal(mem_read, funct3) & aligned_s & ~(mem_read & mem_write);
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be         = 4'b1111;
    store_data = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << addr_lo;
        store_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_data = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        store_data = wdata;
      end
    endcase
  end

  assign lane_s = rdata >> {ld_addr_lo, 3'b000};

  // Load extraction from the captured lane.
  always_comb begin
    load_data = lane_s;
    case (ld_funct3)
      F3_B:    load_data = {{24{lane_s[7]}}, lane_s[7:0]};
      F3_H:    load_data = {{16{lane_s[15]}}, lane_s[15:0]};
      F3_BU:   load_data = {24'd0, lane_s[7:0]};
      F3_HU:   load_data = {16'd0, lane_s[15:0]};
      default: load_data = lane_s;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access controller: accepts one aligned load/store, drives the
// memory request until ack or timeout, and returns load writeback data.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd,
  input  logic [AW-1:0]     addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  mem_access_ctrl_if.master dmem,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          op_s, op_ok_s, accept_s;
  logic [3:0]    be_s;
  logic [31:0]   store_data_s, load_data_s;
  logic          req_r, req_s, misalign_r, misalign_s, timeout_r, timeout_s;
  logic          wb_valid_r, wb_valid_s;
  logic [4:0]    wb_rd_r, wb_rd_s;
  logic [31:0]   wb_data_r, wb_data_s;
  logic          we_r, load_r, m2r_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r;
  logic [3:0]    be_r;
  logic [2:0]    f3_r;
  logic [1:0]    lo_r;
  logic [4:0]    rd_r;

  lsu_align u_align (
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .wdata      (wdata),
    .ld_funct3  (f3_r),
    .ld_addr_lo (lo_r),
    .rdata      (dmem.dmem_rdata),
    .op_ok      (op_ok_s),
    .be         (be_s),
    .store_data (store_data_s),
    .load_data  (load_data_s)
  );

  assign op_s     = valid_in & (mem_read | mem_write);
  assign accept_s = (state_r == IDLE) & op_s & op_ok_s;
  // Combinational so the pipeline freezes in the same cycle; forced low in reset.
  assign stall    = rst_n & (accept_s | (state_r == REQ));

  // Next state, wait counter and next values of the registered outputs.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    req_s      = req_r;
    misalign_s = 1'b0;
    timeout_s  = 1'b0;
    wb_valid_s = 1'b0;
    wb_rd_s    = 5'd0;
    wb_data_s  = 32'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = REQ;
          cnt_s   = {CW{1'b0}};
          req_s   = 1'b1;
        end else begin
          misalign_s = op_s;
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          req_s = 1'b0;
          if (load_r) begin
            state_s    = RESP;
            wb_valid_s = m2r_r;
            wb_rd_s    = rd_r;
            wb_data_s  = load_data_s;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r == CW'(TIMEOUT - 1)) begin
          // This REQ cycle would bring the count to TIMEOUT; ack above has priority.
          req_s     = 1'b0;
          timeout_s = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered request, error pulses and writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_r      <= 1'b0;
      misalign_r <= 1'b0;
      timeout_r  <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_rd_r    <= 5'd0;
      wb_data_r  <= 32'd0;
    end else begin
      req_r      <= req_s;
      misalign_r <= misalign_s;
      timeout_r  <= timeout_s;
      wb_valid_r <= wb_valid_s;
      wb_rd_r    <= wb_rd_s;
      wb_data_r  <= wb_data_s;
    end
  end

  // Capture of the accepted operation; held stable for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r  <= {AW{1'b0}};
      wdata_r <= 32'd0;
      be_r    <= 4'd0;
      we_r    <= 1'b0;
      load_r  <= 1'b0;
      m2r_r   <= 1'b0;
      f3_r    <= 3'd0;
      lo_r    <= 2'd0;
      rd_r    <= 5'd0;
    end else if (accept_s) begin
      addr_r  <= {addr[AW-1:2], 2'b00};
      wdata_r <= store_data_s;
      be_r    <= be_s;
      we_r    <= mem_write;
      load_r  <= mem_read;
      m2r_r   <= mem_to_reg;
      f3_r    <= funct3;
      lo_r    <= addr[1:0];
      rd_r    <= rd;
    end else begin
      addr_r  <= addr_r;
    end
  end

  assign dmem.dmem_req   = req_r;
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_be    = be_r;
  assign misalign_err    = misalign_r;
  assign timeout_err     = timeout_r;
  assign wb_valid        = wb_valid_r;
  assign wb_rd           = wb_rd_r;
  assign wb_data         = wb_data_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_to_reg = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd = 5'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;
  logic        stall, wb_valid, misalign_err, timeout_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          checks = 0;
  int          failures = 0;

  mem_access_ctrl_if #(.AW(32)) bus ();

  mem_access_ctrl #(.TIMEOUT(15), .AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_to_reg   (mem_to_reg),
    .funct3       (funct3),
    .rd           (rd),
    .addr         (addr),
    .wdata        (wdata),
    .stall        (stall),
    .dmem         (bus),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic r_en, input logic w_en, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r);
    valid_in = 1'b1; mem_read = r_en; mem_write = w_en; mem_to_reg = r_en;
    funct3 = f3; addr = a; wdata = wd; rd = r;
  endtask

  task automatic clr_op();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] r, input logic [31:0] rdat, input int waits,
                          input logic [31:0] exp_data);
    tick();
    set_op(1'b1, 1'b0, f3, a, 32'd0, r);
    @(negedge clk); chk({tag, "_stall_issue"}, stall, 32'd1);
    tick(); clr_op();
    for (int i = 0; i < waits; i++) begin
      @(negedge clk); chk({tag, "_req_wait"}, bus.dmem_req, 32'd1);
      tick();
    end
    bus.dmem_ack = 1'b1; bus.dmem_rdata = rdat;
    @(negedge clk);
    chk({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
    chk({tag, "_we"}, bus.dmem_we, 32'd0);
    chk({tag, "_stall_req"}, stall, 32'd1);
    tick(); bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'd0;
    @(negedge clk);
    chk({tag, "_wb_valid"}, wb_valid, 32'd1);
    chk({tag, "_wb_data"}, wb_data, exp_data);
    chk({tag, "_wb_rd"}, wb_rd, {27'd0, r});
    chk({tag, "_stall_resp"}, stall, 32'd0);
    chk({tag, "_req_resp"}, bus.dmem_req, 32'd0);
    chk({tag, "_timeout"}, timeout_err, 32'd0);
    tick();
    @(negedge clk); chk({tag, "_wb_drop"}, wb_valid, 32'd0);
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    tick();
    set_op(1'b0, 1'b1, f3, a, wd, 5'd0);
    @(negedge clk); chk({tag, "_stall_issue"}, stall, 32'd1);
    tick(); clr_op();
    @(negedge clk);
    chk({tag, "_req"}, bus.dmem_req, 32'd1);
    chk({tag, "_we"}, bus.dmem_we, 32'd1);
    chk({tag, "_be"}, bus.dmem_be, {28'd0, exp_be});
    chk({tag, "_wdata"}, bus.dmem_wdata, exp_wd);
    chk({tag, "_addr"}, bus.dmem_addr, {a[31:2], 2'b00});
    bus.dmem_ack = 1'b1;
    tick(); bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_req_done"}, bus.dmem_req, 32'd0);
    chk({tag, "_no_wb"}, wb_valid, 32'd0);
    chk({tag, "_stall_done"}, stall, 32'd0);
    tick();
    @(negedge clk); chk({tag, "_no_wb2"}, wb_valid, 32'd0);
  endtask

  task automatic run_bad(input string tag, input logic r_en, input logic w_en,
                         input logic [2:0] f3, input logic [31:0] a);
    tick();
    set_op(r_en, w_en, f3, a, 32'h0, 5'd1);
    @(negedge clk); chk({tag, "_stall"}, stall, 32'd0);
    tick(); clr_op();
    @(negedge clk);
    chk({tag, "_err"}, misalign_err, 32'd1);
    chk({tag, "_req"}, bus.dmem_req, 32'd0);
    chk({tag, "_stall_after"}, stall, 32'd0);
    tick();
    @(negedge clk); chk({tag, "_err_drop"}, misalign_err, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = 32'd0;
    #2 rst_n = 1'b0;
    set_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 5'd3);
    #1;
    chk("rst_stall", stall, 32'd0);
    chk("rst_req", bus.dmem_req, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_be", bus.dmem_be, 32'd0);
    chk("rst_wb_valid", wb_valid, 32'd0);
    chk("rst_misalign", misalign_err, 32'd0);
    chk("rst_timeout", timeout_err, 32'd0);
    tick(); tick();
    @(negedge clk);
    chk("rst_hold_req", bus.dmem_req, 32'd0);
    chk("rst_hold_stall", stall, 32'd0);
    clr_op();
    rst_n = 1'b1;

    run_load("lw_100", 3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 2, 32'hDEADBEEF);
    run_load("lb_103", 3'b000, 32'h103, 5'd6, 32'h80FFFFFF, 0, 32'hFFFFFF80);
    run_load("lbu_103", 3'b100, 32'h103, 5'd7, 32'h80FFFFFF, 1, 32'h00000080);
    run_load("lh_102", 3'b001, 32'h102, 5'd8, 32'h8001_0000, 0, 32'hFFFF8001);
    run_load("lhu_102", 3'b101, 32'h102, 5'd9, 32'hF00D_0000, 0, 32'h0000F00D);
    run_load("lb_101", 3'b000, 32'h101, 5'd10, 32'h0000_7F00, 0, 32'h0000007F);

    run_store("sh_102", 3'b001, 32'h102, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    run_store("sb_101", 3'b000, 32'h101, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    run_store("sw_104", 3'b010, 32'h104, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    run_bad("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101);
    run_bad("lh_mis", 1'b1, 1'b0, 3'b001, 32'h103);
    run_bad("f3_bad", 1'b1, 1'b0, 3'b011, 32'h100);
    run_bad("sbu_bad", 1'b0, 1'b1, 3'b100, 32'h100);
    run_bad("rw_both", 1'b1, 1'b1, 3'b010, 32'h100);

    // Stray ack while idle must not start anything.
    tick(); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h11111111;
    tick();
    @(negedge clk);
    chk("idle_ack_wb", wb_valid, 32'd0);
    chk("idle_ack_req", bus.dmem_req, 32'd0);
    bus.dmem_ack = 1'b0;

    // Timeout: no ack for 15 REQ cycles.
    tick();
    set_op(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 5'd4);
    tick(); clr_op();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); chk("to_req_hold", bus.dmem_req, 32'd1);
      tick();
    end
    @(negedge clk);
    chk("to_req_last", bus.dmem_req, 32'd1);
    chk("to_not_yet", timeout_err, 32'd0);
    tick();
    @(negedge clk);
    chk("to_err", timeout_err, 32'd1);
    chk("to_req_drop", bus.dmem_req, 32'd0);
    chk("to_stall", stall, 32'd0);
    chk("to_no_wb", wb_valid, 32'd0);
    tick();
    @(negedge clk);
    chk("to_err_drop", timeout_err, 32'd0);
    chk("to_no_wb2", wb_valid, 32'd0);

    // Ack on the 15th REQ cycle wins over the timeout.
    run_load("lw_ack15", 3'b010, 32'h204, 5'd11, 32'h0BADF00D, 14, 32'h0BADF00D);

    // Reset in the middle of a request.
    tick();
    set_op(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 5'd12);
    tick(); clr_op();
    @(negedge clk);
    chk("mid_req_up", bus.dmem_req, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.dmem_req, 32'd0);
    chk("mid_rst_stall", stall, 32'd0);
    chk("mid_rst_addr", bus.dmem_addr, 32'd0);
    @(negedge clk);
    chk("mid_rst_wb", wb_valid, 32'd0);
    chk("mid_rst_to", timeout_err, 32'd0);
    chk("mid_rst_mis", misalign_err, 32'd0);
    rst_n = 1'b1;
    run_load("lw_after_rst", 3'b010, 32'h308, 5'd13, 32'h76543210, 1, 32'h76543210);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
